debounced_updown_counter: RTL and testbench

Parametrised successor to the single-input debounced event counter. Synchronises and debounces two raw asynchronous inputs (count enable, direction) and drives a WIDTH-bit up/down counter. The counter supports level or rising-edge counting, wrap or saturate overflow, synchronous clear and load. It sits between board-level pad inputs and the output pins or a status register.

---
 rtl/debounced_updown_counter.sv | 106 ++++++++++
 tb/tb_debounced_updown_counter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/debounced_updown_counter.sv
// Two-input synchroniser/debouncer feeding a WIDTH-bit up/down counter with
// level or edge counting, wrap or saturate limits, clear and load.
module debounced_updown_counter #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 4,
  parameter int DB_CYCLES   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_raw,
  input  logic             dir_raw,
  input  logic             edge_mode,
  input  logic             sat_mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             en_db,
  output logic             dir_db,
  output logic             wrap,
  output logic             at_limit
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] MAX      = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  // Index 0 carries the enable, index 1 the direction.
  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_p0 [2];
  logic [1:0]             db_state_p1;
  logic [CW-1:0]          db_cnt_p1 [2];
  logic                   en_db_q;
  logic                   step;

  assign raw = {dir_raw, en_raw};

  // Next {wrap, count} for a qualified step, honouring wrap/saturate at limits.
  function automatic logic [WIDTH:0] step_next(input logic [WIDTH-1:0] cur,
                                               input logic up,
                                               input logic sat);
    logic [WIDTH:0] r;
    if (up ? (cur == MAX) : (cur == ZERO)) begin
      if (sat) r = {1'b0, cur};
      else     r = {1'b1, (up ? ZERO : MAX)};
    end else begin
      r = {1'b0, (up ? cur + ONE : cur - ONE)};
    end
    return r;
  endfunction

  // Stage p0: synchroniser chains; stage p1: per-input debounce state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        sync_p0[i]   <= '0;
        db_cnt_p1[i] <= '0;
      end
      db_state_p1 <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_p0[i] <= {sync_p0[i][SYNC_STAGES-2:0], raw[i]};
        if (sync_p0[i][SYNC_STAGES-1] == db_state_p1[i]) begin
          db_cnt_p1[i] <= '0;
        end else if (db_cnt_p1[i] == CNT_LAST) begin
          db_state_p1[i] <= sync_p0[i][SYNC_STAGES-1];
          db_cnt_p1[i]   <= '0;
        end else begin
          db_cnt_p1[i] <= db_cnt_p1[i] + CNT_ONE;
        end
      end
    end
  end

  assign en_db  = db_state_p1[0];
  assign dir_db = db_state_p1[1];
  assign step   = edge_mode ? (en_db & ~en_db_q) : en_db;

  // Stage p2: counter and wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      wrap    <= 1'b0;
      en_db_q <= 1'b0;
    end else begin
      en_db_q <= en_db;
      if (clear) begin
        count <= '0;
        wrap  <= 1'b0;
      end else if (load) begin
        count <= load_val;
        wrap  <= 1'b0;
      end else if (step) begin
        {wrap, count} <= step_next(count, dir_db, sat_mode);
      end else begin
        wrap <= 1'b0;
      end
    end
  end

  assign at_limit = dir_db ? (count == MAX) : (count == ZERO);

endmodule

// File: tb/tb_debounced_updown_counter.sv
// Directed bench for debounced_updown_counter (WIDTH=8, 4 sync stages, 16-cycle debounce).
module tb_debounced_updown_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, en_raw, dir_raw, edge_mode, sat_mode, clear, load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         en_db, dir_db, wrap, at_limit;

  int vectors = 0;
  int errs    = 0;
  logic seen;

  debounced_updown_counter #(.WIDTH(W), .SYNC_STAGES(4), .DB_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .en_raw(en_raw), .dir_raw(dir_raw),
    .edge_mode(edge_mode), .sat_mode(sat_mode), .clear(clear), .load(load),
    .load_val(load_val), .count(count), .en_db(en_db), .dir_db(dir_db),
    .wrap(wrap), .at_limit(at_limit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en_raw = 1'b0; dir_raw = 1'b0; edge_mode = 1'b0; sat_mode = 1'b0;
    clear = 1'b0; load = 1'b0; load_val = '0;
    ticks(2);
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_en_db", en_db, 0);
    chk("rst_dir_db", dir_db, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_at_limit", at_limit, 1);

    // Stable enable/up: en_db rises after the 20th edge, counting starts the edge after.
    en_raw = 1'b1; dir_raw = 1'b1;
    ticks(19);
    chk("lat_en_db_19", en_db, 0);
    chk("lat_count_19", count, 0);
    tick();
    chk("lat_en_db_20", en_db, 1);
    chk("lat_dir_db_20", dir_db, 1);
    chk("lat_count_20", count, 0);
    tick();
    chk("lvl_count_21", count, 1);
    tick();
    chk("lvl_count_22", count, 2);
    // Release: en_db stays high for 20 more edges -> 22 counts total.
    en_raw = 1'b0;
    ticks(30);
    chk("rel_en_db", en_db, 0);
    chk("rel_count", count, 22);

    // 10-cycle glitch is rejected.
    seen = 1'b0;
    en_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin tick(); seen |= en_db; end
    en_raw = 1'b0;
    for (int k = 0; k < 40; k++) begin tick(); seen |= en_db; end
    chk("glitch_en_db", seen, 0);
    chk("glitch_count", count, 22);

    // 16-cycle pulse is accepted and counts 16 in level mode.
    seen = 1'b0;
    en_raw = 1'b1;
    for (int k = 0; k < 16; k++) begin tick(); seen |= en_db; end
    en_raw = 1'b0;
    for (int k = 0; k < 50; k++) begin tick(); seen |= en_db; end
    chk("pulse16_seen", seen, 1);
    chk("pulse16_count", count, 8'h26);

    // Edge mode: four pulses of differing length give four counts.
    edge_mode = 1'b1;
    en_raw = 1'b1; ticks(20); en_raw = 1'b0; ticks(40);
    chk("edge_count_1", count, 8'h27);
    en_raw = 1'b1; ticks(30); en_raw = 1'b0; ticks(40);
    en_raw = 1'b1; ticks(25); en_raw = 1'b0; ticks(40);
    en_raw = 1'b1; ticks(45); en_raw = 1'b0; ticks(40);
    chk("edge_count_4", count, 8'h2A);
    edge_mode = 1'b0;

    // Wrap upward: load held while en_db comes up (load beats step).
    en_raw = 1'b1; load = 1'b1; load_val = 8'hFE;
    ticks(25);
    chk("load_step_count", count, 8'hFE);
    load = 1'b0;
    tick();
    chk("wup_count_ff", count, 8'hFF);
    chk("wup_wrap_ff", wrap, 0);
    chk("wup_at_limit", at_limit, 1);
    tick();
    chk("wup_count_00", count, 8'h00);
    chk("wup_wrap_00", wrap, 1);
    tick();
    chk("wup_count_01", count, 8'h01);
    chk("wup_wrap_01", wrap, 0);

    // Wrap downward.
    dir_raw = 1'b0; load = 1'b1; load_val = 8'h01;
    ticks(25);
    chk("wdn_dir_db", dir_db, 0);
    chk("wdn_count_01", count, 8'h01);
    load = 1'b0;
    tick();
    chk("wdn_count_00", count, 8'h00);
    chk("wdn_at_limit", at_limit, 1);
    tick();
    chk("wdn_count_ff", count, 8'hFF);
    chk("wdn_wrap_ff", wrap, 1);
    tick();
    chk("wdn_count_fe", count, 8'hFE);
    chk("wdn_wrap_fe", wrap, 0);

    // Saturate at MAX going up, then reverse direction.
    sat_mode = 1'b1; dir_raw = 1'b1; load = 1'b1; load_val = 8'hFF;
    ticks(25);
    load = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin tick(); seen |= wrap; end
    chk("sat_count", count, 8'hFF);
    chk("sat_at_limit", at_limit, 1);
    dir_raw = 1'b0;
    for (int k = 0; k < 20; k++) begin tick(); seen |= wrap; end
    chk("sat_wrap_never", seen, 0);
    chk("sat_dir_db", dir_db, 0);
    chk("sat_count_hold", count, 8'hFF);
    chk("sat_at_limit_dn", at_limit, 0);
    tick();
    chk("sat_count_fe", count, 8'hFE);

    // Clear beats load beats step.
    clear = 1'b1; load = 1'b1; load_val = 8'h55;
    tick();
    chk("clr_ld_count", count, 8'h00);
    clear = 1'b0; load_val = 8'h5A;
    tick();
    chk("ld_count", count, 8'h5A);
    load = 1'b0;
    tick();
    chk("ld_then_step", count, 8'h59);

    // Reset in the middle of debouncing en (falling) and dir (rising).
    en_raw = 1'b0; dir_raw = 1'b1;
    ticks(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_count", count, 0);
    chk("mrst_en_db", en_db, 0);
    chk("mrst_dir_db", dir_db, 0);
    chk("mrst_wrap", wrap, 0);
    chk("mrst_at_limit", at_limit, 1);
    ticks(19);
    chk("mrst_dir_db_19", dir_db, 0);
    tick();
    chk("mrst_dir_db_20", dir_db, 1);
    chk("mrst_count_end", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
